// File: rtl/sys_pkg.sv
// Shared definitions for the 4x4 systolic array and its result drain stage.
// Holds array geometry, the drain FSM state type and the PE index mapping.
package sys_pkg;

    localparam int unsigned GRID = 4;
    localparam int unsigned NPE  = GRID * GRID;
    localparam int unsigned DW   = 16;
    localparam int unsigned IDXW = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } drain_state_e;

    // Flat index of PE x_y in row-major order.
    function automatic logic [IDXW-1:0] pe_index(input logic [1:0] x, input logic [1:0] y);
        return ({2'b00, y} * 4'd4) + {2'b00, x};
    endfunction

endpackage

// File: rtl/sys_result_buf.sv
// 16-entry result register file with per-entry valid/saturation bits.
// Parallel strobe write; indexed read with unwritten entries masked to zero.
module sys_result_buf
    import sys_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [NPE*DW-1:0] s_out_flat,
    input  logic [NPE-1:0]    sat_flat,
    input  logic [NPE-1:0]    sw_flat,
    input  logic              rd_en,
    input  logic [IDXW-1:0]   rd_idx,
    output logic [DW-1:0]     rd_data,
    output logic              rd_sat,
    output logic              rd_miss,
    output logic [NPE-1:0]    vld,
    output logic              ovw
);

    logic [DW-1:0]  data_r [NPE];
    logic [NPE-1:0] sat_r;
    logic [NPE-1:0] vld_r;
    logic           hit_s;

    // Entry storage: capture every strobed PE; clear only flags on restart.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NPE); i++) begin
                data_r[i] <= {DW{1'b0}};
            end
            sat_r <= {NPE{1'b0}};
            vld_r <= {NPE{1'b0}};
        end else if (clr) begin
            sat_r <= {NPE{1'b0}};
            vld_r <= {NPE{1'b0}};
        end else if (wr_en) begin
            for (int y = 0; y < int'(GRID); y++) begin
                for (int x = 0; x < int'(GRID); x++) begin
                    if (sw_flat[pe_index(2'(x), 2'(y))]) begin
                        data_r[pe_index(2'(x), 2'(y))] <=
                            s_out_flat[pe_index(2'(x), 2'(y)) * DW +: DW];
                        sat_r[pe_index(2'(x), 2'(y))]  <= sat_flat[pe_index(2'(x), 2'(y))];
                        vld_r[pe_index(2'(x), 2'(y))]  <= 1'b1;
                    end
                end
            end
        end
    end

    // Read port and overwrite detection.
    always_comb begin
        hit_s   = rd_en & vld_r[rd_idx];
        rd_miss = rd_en & ~vld_r[rd_idx];
        rd_data = {DW{1'b0}};
        rd_sat  = 1'b0;
        if (hit_s) begin
            rd_data = data_r[rd_idx];
            rd_sat  = sat_r[rd_idx];
        end else begin
            rd_data = {DW{1'b0}};
            rd_sat  = 1'b0;
        end
        ovw = wr_en & (|(sw_flat & vld_r));
    end

    assign vld = vld_r;

endmodule

// File: rtl/sys_result_drain.sv
// Collects the 16 PE results of the systolic array and streams them out in
// index order over valid/ready, with timeout, sticky error flags and done pulse.
module sys_result_drain
    import sys_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NPE*DW-1:0] s_out_flat,
    input  logic [NPE-1:0]    sat_flat,
    input  logic [NPE-1:0]    sw_flat,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DW-1:0]     res_data,
    output logic [3:0]        res_idx,
    output logic              res_sat,
    output logic              res_miss,
    output logic              busy,
    output logic              done,
    output logic              err_ovw,
    output logic              err_tmo
);

    localparam int unsigned CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] TMO_LAST = (TIMEOUT == 0) ? {CW{1'b0}} : CW'(TIMEOUT - 1);

    drain_state_e   state_r, next_s;
    logic [IDXW-1:0] idx_r;
    logic           res_valid_r;
    logic [CW-1:0]  cnt_r;
    logic           err_ovw_r;
    logic           err_tmo_r;

    logic           collect_s;
    logic           full_s;
    logic           tmo_hit_s;
    logic           xfer_s;
    logic           ovw_s;
    logic [NPE-1:0] vld_s;

    assign collect_s = (state_r == ST_COLLECT);

    sys_result_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start),
        .wr_en      (collect_s),
        .s_out_flat (s_out_flat),
        .sat_flat   (sat_flat),
        .sw_flat    (sw_flat),
        .rd_en      (res_valid_r),
        .rd_idx     (idx_r),
        .rd_data    (res_data),
        .rd_sat     (res_sat),
        .rd_miss    (res_miss),
        .vld        (vld_s),
        .ovw        (ovw_s)
    );

    // Next-state decode; start pre-empts every other event.
    always_comb begin
        next_s    = state_r;
        full_s    = &(vld_s | sw_flat);
        tmo_hit_s = (TIMEOUT != 0) && (cnt_r == TMO_LAST);
        xfer_s    = res_valid_r & res_ready;
        if (start) begin
            next_s = ST_COLLECT;
        end else begin
            case (state_r)
                ST_IDLE:    next_s = ST_IDLE;
                ST_COLLECT: next_s = (full_s || tmo_hit_s) ? ST_DRAIN : ST_COLLECT;
                ST_DRAIN:   next_s = (xfer_s && (idx_r == 4'd15)) ? ST_DONE : ST_DRAIN;
                ST_DONE:    next_s = ST_IDLE;
                default:    next_s = ST_IDLE;
            endcase
        end
    end

    // State, drain index, stream valid, phase counter and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= 4'd0;
            res_valid_r <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            err_ovw_r   <= 1'b0;
            err_tmo_r   <= 1'b0;
        end else if (start) begin
            state_r     <= ST_COLLECT;
            idx_r       <= 4'd0;
            res_valid_r <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            err_ovw_r   <= 1'b0;
            err_tmo_r   <= 1'b0;
        end else begin
            state_r <= next_s;
            case (state_r)
                ST_COLLECT: begin
                    if (cnt_r != {CW{1'b1}}) begin
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                    if (ovw_s) begin
                        err_ovw_r <= 1'b1;
                    end
                    if (tmo_hit_s) begin
                        err_tmo_r <= 1'b1;
                    end
                    if (next_s == ST_DRAIN) begin
                        idx_r       <= 4'd0;
                        res_valid_r <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (xfer_s) begin
                        if (idx_r == 4'd15) begin
                            res_valid_r <= 1'b0;
                        end else begin
                            idx_r <= idx_r + 4'd1;
                        end
                    end
                end
                default: begin
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign res_valid = res_valid_r;
    assign res_idx   = res_valid_r ? idx_r : 4'd0;
    assign busy      = (state_r != ST_IDLE);
    assign done      = (state_r == ST_DONE);
    assign err_ovw   = err_ovw_r;
    assign err_tmo   = err_tmo_r;

endmodule

// File: doc/sys_result_drain.md
Name: sys_result_drain

Overview:
- Downstream stage of the 4x4 systolic array.
- Captures the 16 PE accumulator results (s_out, sat) on each PE's result write strobe (se/sw) into a local result buffer.
- Once all 16 are captured, or a timeout expires, streams them out in fixed index order over a valid/ready interface toward the DMA/write-back path.
- Provides sticky status flags and a one-cycle done pulse for the controller.

Parameters:
- NPE, 16, number of PEs; fixed 4x4, flat index i = y*4 + x for PE x_y.
- DW, 16, result data width.
- TIMEOUT, 1024, collect-phase cycle limit; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; begins a new collect phase (same start that launches the array)
- s_out_flat  in  NPE*DW  PE results; bits [i*DW +: DW] belong to PE i
- sat_flat  in  NPE  PE saturation flags; bit i belongs to PE i
- sw_flat  in  NPE  PE result write strobes; bit i belongs to PE i
- res_valid  out  1  stream data valid
- res_ready  in  1  stream consumer ready
- res_data  out  DW  result word
- res_idx  out  4  flat PE index of res_data
- res_sat  out  1  saturation flag of this word
- res_miss  out  1  word was never captured; data forced to 0
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse after the last word transfers
- err_ovw  out  1  sticky: a strobe arrived for an entry that was already valid
- err_tmo  out  1  sticky: collect phase ended by timeout

Behaviour:
- Reset: clk edge with rst_n=0.
  - All outputs go to 0.
  - State IDLE; vld[15:0]=0; buffers=0; timeout counter=0.
- FSM states: IDLE, COLLECT, DRAIN, DONE.
- Restart: start=1 in any state, on the next edge:
  - clear vld, sat buffer, err_ovw, err_tmo and the counter;
  - state=COLLECT, res_valid=0.
  - start has priority over all other events in the same cycle, including a handshake.
- COLLECT:
  - For each i with sw_flat[i]=1: buf[i]<=s_out[i], satb[i]<=sat[i], vld[i]<=1.
  - If vld[i] was already 1: overwrite the entry and set err_ovw.
  - Multiple simultaneous strobes are all captured.
  - The counter increments every cycle.
- COLLECT -> DRAIN when either:
  - (vld | sw_flat) == all ones, evaluated in the cycle of the final strobe; or
  - TIMEOUT != 0 and counter == TIMEOUT-1, which also sets err_tmo.
  - On entry: idx=0 and res_valid=1 on the following edge.
  - Latency: final strobe at cycle N gives res_valid=1 with idx 0 at N+1.
- Strobes outside COLLECT are ignored; no error is raised.
- DRAIN outputs:
  - res_data=buf[idx], res_sat=satb[idx], res_idx=idx.
  - res_miss = ~vld[idx]; when res_miss=1, res_data=0 and res_sat=0.
- DRAIN handshake:
  - A transfer happens when res_valid & res_ready.
  - Outputs hold stable while res_valid=1 and res_ready=0.
  - On transfer with idx<15: idx+1 next cycle; no bubbles, so one word per cycle with ready held high.
  - On transfer with idx==15: res_valid=0, state DONE.
- DONE: done=1 for exactly one cycle, then IDLE. The buffers keep their contents until the next start.
- busy=1 in COLLECT, DRAIN and DONE.
- Error flags stay readable until the next start or reset.
- Counter width: clog2(TIMEOUT)+1, saturating. No arithmetic is applied to data.

Decomposition:
- Shared package sys_pkg holds:
  - NPE and DW;
  - the drain state enum (IDLE/COLLECT/DRAIN/DONE);
  - the index-mapping function y*4+x, used by the array top and by this block.
- One natural sub-module: sys_result_buf.
  - 16-entry register file with per-entry valid/sat and parallel strobe write.
  - Read by idx, with the miss masking applied there.
- FSM, counter and handshake stay in sys_result_drain.

Test Plan:
1. Full in-order drain: start; strobe PE i at cycle 10+i with s_out=16'h0100+i and sat only on i=5; res_ready=1. Expect 16 consecutive words 0x0100..0x010F with idx 0..15, res_sat=1 only at idx 5, done one cycle after idx 15, no error flags.
2. Backpressure: all 16 strobes in one cycle, values 0xA000+i; toggle res_ready 1,0,0,1,... Expect data and idx stable during every ready=0 cycle, each word transferred exactly once, done after the 16th transfer.
3. Timeout: TIMEOUT=32; strobe all PEs except 7 and 12. Expect DRAIN entered 32 cycles after start, err_tmo=1, res_miss=1 with res_data=0 at idx 7 and 12, other words correct.
4. Overwrite: strobe PE 3 with 0x1111, then again with 0x2222 before completion. Expect err_ovw=1 and idx 3 drains 0x2222.
5. Restart mid-drain: after 4 transfers, pulse start. Expect res_valid=0 next cycle, busy=1, flags cleared, no done pulse; a new full collect then drains from idx 0.
6. Reset mid-collect: rst_n=0 for one edge during COLLECT. Expect all outputs 0 and IDLE; subsequent strobes without start are ignored, with busy staying 0.
